mod_i2c_arbiter: RTL and testbench

MOD_I2C_ARBITER -- requirements
Module: mod_i2c_arbiter

---
 rtl/mod_i2c_arbiter.sv | 124 ++++++++++++
 tb/tb_mod_i2c_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_i2c_arbiter.sv
// rtl/mod_i2c_arbiter.sv - two-requester round-robin arbiter in front of a shared WM8731 I2C master
// Grants one write at a time, supervises completion or timeout, then holds the master in reset.

module mod_i2c_arbiter #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000,
  parameter logic [7:0]  RELEASE_CYCLES = 8'd4
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic [1:0] i_req,
  input  logic [6:0] i_reg0,
  input  logic [6:0] i_reg1,
  input  logic [8:0] i_data0,
  input  logic [8:0] i_data1,
  output logic [1:0] o_grant,
  output logic [1:0] o_done,
  output logic [1:0] o_fault,
  output logic [3:0] o_fault_code,
  output logic       o_busy,
  output logic       o_mst_nrst,
  output logic [6:0] o_mst_reg,
  output logic [8:0] o_mst_data,
  input  logic       i_mst_done,
  input  logic [3:0] i_mst_fault_code,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_RUN     = 3'd2,
    S_RELEASE = 3'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        done_s1;
  logic        done_s2;
  logic        owner;
  logic        last;
  logic        winner;
  logic [19:0] run_cnt;
  logic [7:0]  rel_cnt;
  logic        run_timeout;
  logic        run_end;
  logic        rel_last;
  logic [3:0]  run_code;

  always_comb begin
    winner = 1'b0;
    if (i_req == 2'b10) begin
      winner = 1'b1;
    end else if (i_req == 2'b11) begin
      winner = ~last;
    end
  end

  // Compare against count+1 so a zero parameter cannot underflow into a huge limit.
  assign run_timeout = ({1'b0, run_cnt} + 21'd1) >= {1'b0, TIMEOUT_CYCLES};
  assign run_end     = done_s2 || run_timeout;
  assign rel_last    = ({1'b0, rel_cnt} + 9'd1) >= {1'b0, RELEASE_CYCLES};
  assign run_code    = done_s2 ? i_mst_fault_code : 4'hF;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (|i_req) state_nxt = S_GRANT;
      S_GRANT:   state_nxt = S_RUN;
      S_RUN:     if (run_end) state_nxt = S_RELEASE;
      S_RELEASE: if (rel_last) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state        <= S_IDLE;
      done_s1      <= 1'b0;
      done_s2      <= 1'b0;
      owner        <= 1'b0;
      last         <= 1'b1;
      run_cnt      <= 20'd0;
      rel_cnt      <= 8'd0;
      o_done       <= 2'b00;
      o_fault      <= 2'b00;
      o_fault_code <= 4'h0;
      o_mst_reg    <= 7'd0;
      o_mst_data   <= 9'd0;
    end else begin
      state   <= state_nxt;
      done_s1 <= i_mst_done;
      done_s2 <= done_s1;
      o_done  <= 2'b00;
      o_fault <= 2'b00;
      // Operands are captured on the IDLE->GRANT edge so they are already valid during GRANT.
      if (state == S_IDLE && |i_req) begin
        owner      <= winner;
        o_mst_reg  <= winner ? i_reg1 : i_reg0;
        o_mst_data <= winner ? i_data1 : i_data0;
      end
      if (state == S_GRANT) begin
        last    <= owner;
        run_cnt <= 20'd0;
      end else if (state == S_RUN && !run_timeout) begin
        run_cnt <= run_cnt + 20'd1;
      end
      if (state == S_RUN && run_end) begin
        o_done       <= {owner, ~owner};
        o_fault      <= (run_code != 4'h0) ? {owner, ~owner} : 2'b00;
        o_fault_code <= run_code;
        rel_cnt      <= 8'd0;
      end else if (state == S_RELEASE) begin
        rel_cnt <= rel_cnt + 8'd1;
      end
    end
  end

  // Decoded from the state register so reset drops the master enable without waiting for a clock.
  assign o_mst_nrst = (state == S_GRANT) || (state == S_RUN);
  assign o_grant    = (state == S_GRANT) ? {owner, ~owner} : 2'b00;
  assign o_busy     = (state != S_IDLE);
  assign o_state    = state;

endmodule

// File: tb/tb_mod_i2c_arbiter.sv
// tb/tb_mod_i2c_arbiter.sv - scoreboard bench for mod_i2c_arbiter with a behavioural I2C master
module tb_mod_i2c_arbiter;
  localparam logic [19:0] TO = 20'd1000;
  localparam logic [7:0]  RC = 8'd4;

  logic       clk = 1'b0;
  logic       nrst;
  logic [1:0] i_req;
  logic [6:0] i_reg0, i_reg1;
  logic [8:0] i_data0, i_data1;
  logic [1:0] o_grant, o_done, o_fault;
  logic [3:0] o_fault_code;
  logic       o_busy, o_mst_nrst;
  logic [6:0] o_mst_reg;
  logic [8:0] o_mst_data;
  logic       i_mst_done;
  logic [3:0] i_mst_fault_code;
  logic [2:0] o_state;

  always #5 clk = ~clk;

  mod_i2c_arbiter #(.TIMEOUT_CYCLES(TO), .RELEASE_CYCLES(RC)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_req(i_req),
    .i_reg0(i_reg0), .i_reg1(i_reg1), .i_data0(i_data0), .i_data1(i_data1),
    .o_grant(o_grant), .o_done(o_done), .o_fault(o_fault), .o_fault_code(o_fault_code),
    .o_busy(o_busy), .o_mst_nrst(o_mst_nrst), .o_mst_reg(o_mst_reg), .o_mst_data(o_mst_data),
    .i_mst_done(i_mst_done), .i_mst_fault_code(i_mst_fault_code), .o_state(o_state)
  );

  typedef struct { int id; logic [6:0] addr; logic [8:0] data; } grant_t;
  typedef struct { int id; logic [3:0] code; bit to; } done_t;
  typedef struct { int dly; logic [3:0] code; bit to; } plan_t;

  grant_t exp_grant[$];
  done_t  exp_done[$];
  plan_t  plans[$];
  int     checks = 0;
  int     errors = 0;
  int     model_last = 1;

  function automatic logic [1:0] onehot(input int id);
    return (id == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Master: raises done a planned number of cycles after being enabled, never if the plan is a timeout.
  initial begin
    plan_t cur;
    int    cnt = 0;
    bit    active = 0;
    cur = '{dly: 0, code: 4'h0, to: 1'b1};
    i_mst_done = 1'b0;
    i_mst_fault_code = 4'h0;
    forever begin
      @(negedge clk);
      if (!o_mst_nrst) begin
        i_mst_done = 1'b0;
        active = 0;
        cnt = 0;
      end else begin
        if (!active) begin
          active = 1;
          cnt = 0;
          if (plans.size() != 0) cur = plans.pop_front();
          else cur = '{dly: 0, code: 4'h0, to: 1'b1};
          i_mst_fault_code = cur.code;
        end else begin
          cnt++;
        end
        if (!cur.to && cnt >= cur.dly) i_mst_done = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT pulses grant or done and checks protocol timing.
  initial begin
    grant_t     g;
    done_t      e;
    int         run_len = 0, rel_len = 0, since = 0;
    bit         have_prev = 0;
    logic [2:0] prev_state = 3'd0;
    logic [6:0] held_reg = 7'd0;
    logic [8:0] held_data = 9'd0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        have_prev = 0; run_len = 0; rel_len = 0; prev_state = 3'd0;
        continue;
      end
      since++;
      if (o_state == 3'd1) run_len = 0;
      if (o_state == 3'd2) run_len++;
      if (o_state == 3'd3) rel_len++;
      if (prev_state == 3'd3 && o_state != 3'd3) begin
        chk("release_len", rel_len, RC);
        rel_len = 0;
      end
      if (o_state == 3'd2) chk("mst_nrst_run", o_mst_nrst, 1);
      if (o_state == 3'd3) chk("mst_nrst_release", o_mst_nrst, 0);
      if (o_state == 3'd2 || o_state == 3'd3) begin
        chk("hold_reg", o_mst_reg, held_reg);
        chk("hold_data", o_mst_data, held_data);
      end
      if (o_grant != 2'b00) begin
        if (have_prev) chk("grant_spacing", since >= 3 + int'(RC), 1);
        have_prev = 1; since = 0;
        held_reg = o_mst_reg; held_data = o_mst_data;
        if (exp_grant.size() == 0) begin
          chk("unexpected_grant", o_grant, 0);
        end else begin
          g = exp_grant.pop_front();
          chk("grant", o_grant, onehot(g.id));
          chk("grant_reg", o_mst_reg, g.addr);
          chk("grant_data", o_mst_data, g.data);
        end
      end
      if (o_done != 2'b00 || o_fault != 2'b00) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_done", {o_done, o_fault}, 0);
        end else begin
          e = exp_done.pop_front();
          chk("done", o_done, onehot(e.id));
          chk("fault", o_fault, (e.code != 4'h0) ? onehot(e.id) : 2'b00);
          chk("fault_code", o_fault_code, e.code);
          if (e.to) chk("timeout_len", run_len, TO);
          else chk("run_before_timeout", run_len < int'(TO), 1);
        end
      end
      prev_state = o_state;
    end
  end

  // Reference model: decides grant order from the round-robin rule and queues every expected outcome.
  task automatic run_round(input logic [1:0] pat, input bit late1,
                           input logic [6:0] r0, input logic [6:0] r1,
                           input logic [8:0] dv0, input logic [8:0] dv1,
                           input int dl0, input int dl1,
                           input logic [3:0] c0, input logic [3:0] c1,
                           input bit t0, input bit t1);
    int order[$];
    int n = 0;
    bit raised = 0;
    if (late1) order = {0, 1};
    else if (pat == 2'b01) order = {0};
    else if (pat == 2'b10) order = {1};
    else if (model_last == 1) order = {0, 1};
    else order = {1, 0};
    foreach (order[k]) begin
      int id = order[k];
      bit t = id ? t1 : t0;
      exp_grant.push_back('{id: id, addr: id ? r1 : r0, data: id ? dv1 : dv0});
      plans.push_back('{dly: id ? dl1 : dl0, code: id ? c1 : c0, to: t});
      exp_done.push_back('{id: id, code: t ? 4'hF : (id ? c1 : c0), to: t});
      model_last = id;
    end
    @(negedge clk);
    i_reg0 = r0; i_reg1 = r1; i_data0 = dv0; i_data1 = dv1;
    i_req = late1 ? 2'b01 : pat;
    while ((exp_done.size() != 0 || o_busy || i_req != 2'b00) && n < 6000) begin
      @(negedge clk);
      n++;
      if (o_grant[0]) i_req[0] = 1'b0;
      if (o_grant[1]) i_req[1] = 1'b0;
      if (late1 && !raised && o_state == 3'd3) begin
        i_req[1] = 1'b1;
        raised = 1;
      end
    end
    chk("round_complete", n < 6000, 1);
  endtask

  task automatic reset_mid_run();
    int n = 0;
    exp_grant.push_back('{id: 0, addr: 7'h11, data: 9'h155});
    plans.push_back('{dly: 0, code: 4'h0, to: 1'b1});
    @(negedge clk);
    i_reg0 = 7'h11; i_data0 = 9'h155; i_req = 2'b01;
    while (o_state != 3'd2 && n < 100) begin
      if (o_grant[0]) i_req[0] = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("reached_run", o_state, 2);
    repeat (20) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("rst_mst_nrst", o_mst_nrst, 0);
    chk("rst_state", o_state, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_grant", o_grant, 0);
    exp_done.delete(); plans.delete(); exp_grant.delete();
    model_last = 1;
    i_req = 2'b00;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (20) @(negedge clk);
    chk("fault_code_after_reset", o_fault_code, 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0;
    i_req = 2'b00;
    i_reg0 = 7'd0; i_reg1 = 7'd0; i_data0 = 9'd0; i_data1 = 9'd0;
    repeat (3) @(negedge clk);
    chk("reset_state", o_state, 0);
    chk("reset_mst_nrst", o_mst_nrst, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_pulses", {o_grant, o_done, o_fault}, 0);
    chk("reset_fault_code", o_fault_code, 0);
    chk("reset_mst_reg", o_mst_reg, 0);
    chk("reset_mst_data", o_mst_data, 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    run_round(2'b11, 0, 7'h01, 7'h02, 9'h0AA, 9'h155, 10, 12, 4'h0, 4'h0, 0, 0);
    run_round(2'b11, 0, 7'h03, 7'h04, 9'h011, 9'h022, 3, 20, 4'h0, 4'h0, 0, 0);
    run_round(2'b01, 0, 7'h06, 7'h00, 9'h006, 9'h000, 100, 0, 4'h0, 4'h0, 0, 0);
    chk("clean_fault_code", o_fault_code, 0);
    run_round(2'b10, 0, 7'h00, 7'h07, 9'h000, 9'h1FF, 0, 7, 4'h0, 4'h3, 0, 0);
    chk("fault_code_kept", o_fault_code, 4'h3);
    run_round(2'b01, 0, 7'h08, 7'h00, 9'h0F0, 9'h000, 5, 0, 4'h0, 4'h0, 0, 0);
    chk("fault_code_cleared", o_fault_code, 0);
    run_round(2'b01, 0, 7'h09, 7'h00, 9'h012, 9'h000, 0, 0, 4'h0, 4'h0, 1, 0);
    chk("fault_code_timeout", o_fault_code, 4'hF);
    run_round(2'b01, 1, 7'h0A, 7'h0B, 9'h0C0, 9'h0D0, 8, 9, 4'h0, 4'h0, 0, 0);
    reset_mid_run();
    run_round(2'b11, 0, 7'h0C, 7'h0D, 9'h101, 9'h102, 4, 6, 4'h0, 4'h5, 0, 0);

    for (int i = 0; i < 20; i++) begin
      logic [1:0] pat;
      logic [3:0] c0, c1;
      bit late, t0, t1;
      pat  = 2'($urandom_range(1, 3));
      late = (pat == 2'b01) && ($urandom_range(0, 4) == 0);
      t0   = ($urandom_range(0, 14) == 0);
      t1   = ($urandom_range(0, 14) == 0);
      c0   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      c1   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      run_round(pat, late, 7'($urandom), 7'($urandom), 9'($urandom), 9'($urandom),
                int'($urandom_range(0, 60)), int'($urandom_range(0, 60)), c0, c1, t0, t1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_grant.size() + exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
